// File: rtl/tt_mux_pkg.sv
// Shared widths and FSM state encoding for the muxperiment project-select controller.
package tt_mux_pkg;

  localparam int IW_W = 18;
  localparam int OW_W = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GUARD  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

endpackage

// File: rtl/tt_sync2.sv
// Two-flop synchronizer for one asynchronous pad control input.
module tt_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/tt_mux_ctrl.sv
// Project-select controller: address counter, guard-interval FSM, ena/iw gating
// and the registered ow return mux for the muxperiment wrapper array.
module tt_mux_ctrl
  import tt_mux_pkg::*;
#(
  parameter int NUM_PROJ     = 16,
  parameter int ADDR_W       = 4,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sel_ena,
  input  logic                     sel_inc,
  input  logic                     sel_clr_n,
  input  logic [IW_W-1:0]          iw_in,
  input  logic [NUM_PROJ*OW_W-1:0] ow_bus,
  output logic [NUM_PROJ-1:0]      ena,
  output logic [IW_W-1:0]          iw_out,
  output logic [OW_W-1:0]          ow_out,
  output logic [ADDR_W-1:0]        addr,
  output logic                     busy
);

  localparam int                CNT_W     = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_PROJ - 1);

  logic        w_ena_s;
  logic        w_inc_s;
  logic        w_clr_n_s;
  logic        w_inc_rise;
  logic        w_addr_chg;
  logic        w_cnt_load;
  logic        w_active;
  logic        w_in_range;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              r_inc_d;
  logic [CNT_W-1:0]  r_cnt;
  state_e            r_state;
  state_e            w_state_nxt;
  logic [OW_W-1:0]   r_ow;

  tt_sync2 u_sync_ena (.clk(clk), .rst_n(rst_n), .d(sel_ena),   .q(w_ena_s));
  tt_sync2 u_sync_inc (.clk(clk), .rst_n(rst_n), .d(sel_inc),   .q(w_inc_s));
  tt_sync2 u_sync_clr (.clk(clk), .rst_n(rst_n), .d(sel_clr_n), .q(w_clr_n_s));

  assign w_inc_rise = w_inc_s & ~r_inc_d;

  // Clear dominates; an increment edge seen while clear is held is discarded.
  always_comb begin
    w_addr_nxt = r_addr;
    if (!w_clr_n_s) begin
      w_addr_nxt = '0;
    end else if (w_inc_rise) begin
      w_addr_nxt = (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
    end
  end

  // Looking at the next address lets the FSM leave ACTIVE on the same edge the
  // address moves, so ena never decodes the new address before its guard.
  assign w_addr_chg = (w_addr_nxt != r_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_inc_d <= 1'b0;
    end else begin
      r_addr  <= w_addr_nxt;
      r_inc_d <= w_inc_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ena_s) begin
          w_state_nxt = GUARD;
          w_cnt_load  = 1'b1;
        end
      end
      GUARD: begin
        if (!w_ena_s) begin
          w_state_nxt = IDLE;
        end else if (w_addr_chg) begin
          w_cnt_load  = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!w_ena_s) begin
          w_state_nxt = IDLE;
        end else if (w_addr_chg) begin
          w_state_nxt = GUARD;
          w_cnt_load  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_cnt_load) begin
      r_cnt <= CNT_INIT;
    end else if (r_state == GUARD && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_active   = (r_state == ACTIVE);
    w_in_range = (int'(r_addr) < NUM_PROJ);
    ena        = (w_active && w_in_range) ? (NUM_PROJ'(1) << r_addr) : '0;
    iw_out     = w_active ? iw_in : '0;
    busy       = (r_state == GUARD);
  end

  // Zero on the first ACTIVE cycle because the register still sees GUARD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ow <= '0;
    end else if (w_active && w_in_range) begin
      r_ow <= ow_bus[OW_W*r_addr +: OW_W];
    end else begin
      r_ow <= '0;
    end
  end

  assign ow_out = r_ow;
  assign addr   = r_addr;

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// Directed bench for tt_mux_ctrl: reset, enable latency, wrap, clear priority,
// drop during guard and asynchronous reset while active.
module tb_tt_mux_ctrl;

  localparam int NUM_PROJ = 16;
  localparam int ADDR_W   = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   sel_ena;
  logic                   sel_inc;
  logic                   sel_clr_n;
  logic [17:0]            iw_in;
  logic [NUM_PROJ*24-1:0] ow_bus;
  logic [NUM_PROJ-1:0]    ena;
  logic [17:0]            iw_out;
  logic [23:0]            ow_out;
  logic [ADDR_W-1:0]      addr;
  logic                   busy;

  int n_chk = 0;
  int n_err = 0;

  tt_mux_ctrl #(.NUM_PROJ(NUM_PROJ), .ADDR_W(ADDR_W), .GUARD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sel_ena(sel_ena), .sel_inc(sel_inc),
    .sel_clr_n(sel_clr_n), .iw_in(iw_in), .ow_bus(ow_bus), .ena(ena),
    .iw_out(iw_out), .ow_out(ow_out), .addr(addr), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ow_val(input int k);
    return {8'h5A, 8'(k), 8'(8'hF0 ^ k)};
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_inc();
    sel_inc = 1'b1;
    step(1);
    sel_inc = 1'b0;
  endtask

  initial begin
    logic [NUM_PROJ-1:0] ena_acc;
    int exp_a;

    for (int k = 0; k < NUM_PROJ; k++) ow_bus[24*k +: 24] = ow_val(k);

    // Reset with arbitrary pad activity
    rst_n     = 1'b0;
    sel_ena   = 1'b1;
    sel_inc   = 1'($urandom);
    sel_clr_n = 1'($urandom);
    iw_in     = 18'h3FFFF;
    step(2);
    check("rst_ena",  64'(ena),    64'h0);
    check("rst_iw",   64'(iw_out), 64'h0);
    check("rst_ow",   64'(ow_out), 64'h0);
    check("rst_addr", 64'(addr),   64'h0);
    check("rst_busy", 64'(busy),   64'h0);

    sel_ena   = 1'b0;
    sel_inc   = 1'b0;
    sel_clr_n = 1'b1;
    iw_in     = 18'h2A5C3;
    rst_n     = 1'b1;
    step(3);

    // Enable from IDLE: 2 sync + 1 state + 4 guard cycles
    sel_ena = 1'b1;
    step(2);
    check("en_idle_busy", 64'(busy), 64'h0);
    step(1);
    check("en_guard_busy", 64'(busy),   64'h1);
    check("en_guard_ena",  64'(ena),    64'h0);
    check("en_guard_iw",   64'(iw_out), 64'h0);
    step(3);
    check("en_guard_end_busy", 64'(busy), 64'h1);
    check("en_guard_end_ena",  64'(ena),  64'h0);
    step(1);
    check("en_act_ena",  64'(ena),    64'h0001);
    check("en_act_busy", 64'(busy),   64'h0);
    check("en_act_ow0",  64'(ow_out), 64'h0);
    check("en_act_iw",   64'(iw_out), 64'h2A5C3);
    step(1);
    check("en_act_ow", 64'(ow_out), 64'h5A00F0);
    iw_in = 18'h15A3C;
    #1;
    check("en_iw_track", 64'(iw_out), 64'h15A3C);

    // Sixteen increments wrap back to 0, each through a full guard
    for (int i = 1; i <= NUM_PROJ; i++) begin
      exp_a = i % NUM_PROJ;
      pulse_inc();
      step(2);
      check("inc_addr",       64'(addr), 64'(exp_a));
      check("inc_guard_busy", 64'(busy), 64'h1);
      check("inc_guard_ena",  64'(ena),  64'h0);
      step(3);
      check("inc_guard_hold", 64'(busy | (|ena)), 64'h1);
      step(1);
      check("inc_act_ena", 64'(ena), 64'(NUM_PROJ'(1) << exp_a));
      step(1);
      check("inc_ow", 64'(ow_out), 64'(ow_val(exp_a)));
    end
    check("wrap_addr", 64'(addr), 64'h0);

    // Clear priority at addr 5
    for (int i = 0; i < 5; i++) begin
      pulse_inc();
      step(2);
    end
    step(5);
    check("clr_pre_addr", 64'(addr), 64'h5);
    check("clr_pre_ena",  64'(ena),  64'h0020);
    sel_clr_n = 1'b0;
    pulse_inc();
    step(2);
    check("clr_win_addr", 64'(addr), 64'h0);
    check("clr_win_busy", 64'(busy), 64'h1);
    for (int i = 0; i < 2; i++) begin
      pulse_inc();
      step(2);
      check("clr_hold_addr", 64'(addr), 64'h0);
    end
    sel_clr_n = 1'b1;
    step(3);
    check("clr_rel_addr", 64'(addr), 64'h0);
    pulse_inc();
    step(2);
    check("clr_after_inc", 64'(addr), 64'h1);
    step(5);
    check("clr_after_ena", 64'(ena), 64'h0002);

    // Drop sel_ena shortly after entering GUARD
    pulse_inc();
    step(2);
    check("drop_addr", 64'(addr), 64'h2);
    check("drop_busy", 64'(busy), 64'h1);
    sel_ena = 1'b0;
    ena_acc = '0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      ena_acc |= ena;
    end
    check("drop_ena_never", 64'(ena_acc), 64'h0);
    check("drop_idle_busy", 64'(busy),    64'h0);

    // Increment in IDLE to 3, activate, then asynchronous reset
    pulse_inc();
    step(2);
    check("idle_inc_addr", 64'(addr), 64'h3);
    check("idle_inc_busy", 64'(busy), 64'h0);
    sel_ena = 1'b1;
    step(7);
    check("ar_act_ena", 64'(ena), 64'h0008);
    step(1);
    check("ar_act_ow", 64'(ow_out), 64'h5A03F3);
    check("ar_act_iw", 64'(iw_out), 64'h15A3C);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("ar_ena",  64'(ena),    64'h0);
    check("ar_ow",   64'(ow_out), 64'h0);
    check("ar_iw",   64'(iw_out), 64'h0);
    check("ar_addr", 64'(addr),   64'h0);
    check("ar_busy", 64'(busy),   64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
